// File: rtl/fhe_instr_scheduler_if.sv
// Purpose : Wishbone slave and FHE core issue/complete signals of the instruction scheduler.
// Latency : n/a (signal bundle only).
// Backpressure: Wishbone ack handshake on the bus side, start/done handshake on the core side.
//   slave  modport: the scheduler (receives Wishbone requests, drives the core).
//   master modport: firmware/bus master plus compute core (drives requests and core_done).
interface fhe_instr_scheduler_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  wbs_stb_i;
    logic                  wbs_cyc_i;
    logic                  wbs_we_i;
    logic [3:0]            wbs_sel_i;
    logic [31:0]           wbs_adr_i;
    logic [31:0]           wbs_dat_i;
    logic                  wbs_ack_o;
    logic [31:0]           wbs_dat_o;
    logic                  core_start;
    logic [1:0]            core_op;
    logic [ADDR_WIDTH-1:0] core_src_a;
    logic [ADDR_WIDTH-1:0] core_src_b;
    logic [ADDR_WIDTH-1:0] core_dst;
    logic                  core_done;
    logic                  irq_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        output core_start, core_op, core_src_a, core_src_b, core_dst,
        input  core_done,
        output irq_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        input  core_start, core_op, core_src_a, core_src_b, core_dst,
        output core_done,
        input  irq_o
    );
endinterface

// File: rtl/fhe_instr_scheduler.sv
// Purpose : queues FHE instruction words written over Wishbone and issues them in order to the core.
// Latency : ack 1 cycle after request; core_start rises 1 edge after the push edge when idle.
// Backpressure: full FIFO drops pushes (sticky overflow); the core is throttled by start/done.
// Ports: wb_clk_i clock, wb_rst_i async active-high reset, bus (fhe_instr_scheduler_if.slave):
//   Wishbone slave (stb/cyc/we/sel/adr/dat_i -> ack/dat_o), core issue (core_start/op/src_a/src_b/dst),
//   core_done completion pulse, irq_o drain interrupt.
// Optional feature: define SCHED_IRQ_EN to enable irq_o and the sticky irq_pending status bit [5].
module fhe_instr_scheduler #(
    parameter int          QDEPTH      = 4,
    parameter int          ADDR_WIDTH  = 9,
    parameter logic [31:0] OPCODE_ADDR = 32'h3000_0000,
    parameter logic [31:0] STATUS_ADDR = 32'h3000_0400
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    fhe_instr_scheduler_if.slave  bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t        state;
    logic [28:0]   fifo_mem [QDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          spurious_done;
    logic [15:0]   comp_cnt;
    logic          irq_bit;

    logic          hit_op, hit_st, acc, wr_op;
    logic          fifo_full, fifo_empty;
    logic          push_req, push, drop, clr, pop;
    logic          done_ok, spur;
    logic [28:0]   head;
    logic [31:0]   status_word;
    logic          unused_ok;

    // Byte selects and the reserved bit 29 carry no meaning here.
    assign unused_ok = ^{bus.wbs_sel_i, bus.wbs_dat_i[29]};

    // A transaction is accepted only on a decoded address while ack is low,
    // so a held strobe produces one ack every second cycle.
    assign hit_op = (bus.wbs_adr_i == OPCODE_ADDR);
    assign hit_st = (bus.wbs_adr_i == STATUS_ADDR);
    assign acc    = bus.wbs_stb_i & bus.wbs_cyc_i & ~bus.wbs_ack_o & (hit_op | hit_st);
    assign wr_op  = acc & bus.wbs_we_i & hit_op;

    // Fullness is judged before any same-cycle pop.
    assign fifo_full  = (count == CW'(QDEPTH));
    assign fifo_empty = (count == '0);
    assign push_req   = wr_op & bus.wbs_dat_i[31];
    assign push       = push_req & ~fifo_full;
    assign drop       = push_req & fifo_full;
    assign clr        = wr_op & ~bus.wbs_dat_i[31] & bus.wbs_dat_i[30];
    assign pop        = (state == ST_IDLE) & ~fifo_empty;
    assign head       = fifo_mem[rd_ptr];

    assign done_ok = (state == ST_WAIT) & bus.core_done;
    assign spur    = (state != ST_WAIT) & bus.core_done;

    // Status reflects register state before any push in the same cycle.
    assign status_word = {comp_cnt,
                          {{(8-CW){1'b0}}, count},
                          2'b00,
                          irq_bit,
                          spurious_done,
                          overflow,
                          (state != ST_IDLE),
                          fifo_full,
                          fifo_empty};

    // Wishbone response: one-cycle ack, read data only during the ack cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            bus.wbs_ack_o <= 1'b0;
            bus.wbs_dat_o <= '0;
        end else if (acc) begin
            bus.wbs_ack_o <= 1'b1;
            bus.wbs_dat_o <= (hit_st & ~bus.wbs_we_i) ? status_word : 32'h0;
        end else begin
            bus.wbs_ack_o <= 1'b0;
            bus.wbs_dat_o <= '0;
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge wb_clk_i) begin
        if (push)
            fifo_mem[wr_ptr] <= bus.wbs_dat_i[28:0];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            overflow      <= 1'b0;
            spurious_done <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new event in the same cycle as a clear wins, so it is never lost.
            overflow      <= (overflow & ~clr) | drop;
            spurious_done <= (spurious_done & ~clr) | spur;
        end
    end

    // Issue sequencer; core_* fields hold the last issued instruction.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state          <= ST_IDLE;
            bus.core_start <= 1'b0;
            bus.core_op    <= '0;
            bus.core_src_a <= '0;
            bus.core_src_b <= '0;
            bus.core_dst   <= '0;
            comp_cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state          <= ST_ISSUE;
                        bus.core_start <= 1'b1;
                        bus.core_op    <= head[1:0];
                        bus.core_src_a <= ADDR_WIDTH'(head[10:2]);
                        bus.core_src_b <= ADDR_WIDTH'(head[19:11]);
                        bus.core_dst   <= ADDR_WIDTH'(head[28:20]);
                    end
                end
                ST_ISSUE: begin
                    state          <= ST_WAIT;
                    bus.core_start <= 1'b0;
                end
                ST_WAIT: begin
                    if (bus.core_done) begin
                        state    <= ST_IDLE;
                        comp_cnt <= comp_cnt + 16'd1;
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    bus.core_start <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCHED_IRQ_EN
    logic irq_pending;
    logic drained;

    // Queue is drained when this completion leaves nothing queued (no pop can occur in WAIT).
    assign drained = done_ok & fifo_empty & ~push;
    assign irq_bit = irq_pending;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            bus.irq_o   <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            bus.irq_o   <= drained;
            irq_pending <= (irq_pending & ~clr) | drained;
        end
    end
`else
    assign irq_bit   = 1'b0;
    assign bus.irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_fhe_instr_scheduler.sv
// Directed bench for fhe_instr_scheduler: Wishbone push/status, issue timing, overflow,
// spurious done, reset mid-operation, in-order drain and drain interrupt.
module tb_fhe_instr_scheduler;
    localparam logic [31:0] OPA = 32'h3000_0000;
    localparam logic [31:0] STA = 32'h3000_0400;
`ifdef SCHED_IRQ_EN
    localparam logic [31:0] IRQB = 32'h0000_0020;
    localparam int          IRQN = 1;
`else
    localparam logic [31:0] IRQB = 32'h0;
    localparam int          IRQN = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fhe_instr_scheduler_if #(.ADDR_WIDTH(9)) bus ();

    fhe_instr_scheduler #(
        .QDEPTH(4), .ADDR_WIDTH(9), .OPCODE_ADDR(OPA), .STATUS_ADDR(STA)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus     (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_done = 0;
    int nxt     = 0;
    int irq_cnt = 0;
    int irq_cyc = -1;
    logic [1:0] start_ops [$];
    int         start_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Log every issue and interrupt cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.core_start) begin
            start_ops.push_back(bus.core_op);
            start_cyc.push_back(cyc);
        end
        if (bus.irq_o) begin
            irq_cnt++;
            irq_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [1:0] op, input logic [8:0] sa,
                                        input logic [8:0] sb, input logic [8:0] d);
        return {1'b1, 2'b00, d, sb, sa, op};
    endfunction

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           output logic [31:0] rd, output logic ok);
        @(negedge clk);
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = 4'hf;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        ok = 1'b0;
        rd = '0;
        for (int i = 0; i < 6 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (bus.wbs_ack_o) begin
                ok = 1'b1;
                rd = bus.wbs_dat_o;
            end
        end
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] rd;
        logic ok;
        wb_xfer(1'b1, adr, dat, rd, ok);
        chk("write_ack", 32'(ok), 32'd1);
    endtask

    task automatic rd_status(input string tag, input logic [31:0] exp);
        logic [31:0] rd;
        logic ok;
        wb_xfer(1'b0, STA, 32'h0, rd, ok);
        chk("read_ack", 32'(ok), 32'd1);
        chk(tag, rd, exp);
    endtask

    task automatic pulse_done();
        bus.core_done = 1'b1;
        @(posedge clk);
        #1;
        bus.core_done = 1'b0;
        last_done = cyc;
    endtask

    // Wait for the next logged issue, check its opcode (and the one-idle-cycle gap),
    // then answer with core_done sampled 3 edges after the start edge.
    task automatic serve(input logic [1:0] exp_op, input bit gap);
        int k;
        int w;
        k = nxt;
        nxt++;
        w = 0;
        while (start_ops.size() <= k && w < 40) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (start_ops.size() <= k) begin
            chk("start_timeout", 32'd0, 32'd1);
        end else begin
            chk("issue_op", 32'(start_ops[k]), 32'(exp_op));
            if (gap)
                chk("issue_gap", 32'(start_cyc[k]), 32'(last_done + 1));
            while (cyc < start_cyc[k] + 2) begin
                @(posedge clk);
                #1;
            end
            pulse_done();
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic ok;
        int acks;
        int irq_base;

        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
        bus.core_done = 1'b0;

        // Reset values
        #2;
        chk("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
        chk("rst_dat", bus.wbs_dat_o, 32'd0);
        chk("rst_start", 32'(bus.core_start), 32'd0);
        chk("rst_fields", {3'b0, bus.core_op, bus.core_src_a, bus.core_src_b, bus.core_dst}, 32'd0);
        chk("rst_irq", 32'(bus.irq_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_status("status_after_reset", 32'h0000_0001);

        // Single add: start one edge after the push edge, for exactly one cycle
        wr(OPA, enc(2'b10, 9'd0, 9'd100, 9'd50));
        chk("start_before_e1", 32'(bus.core_start), 32'd0);
        @(posedge clk);
        #1;
        chk("start_at_e1", 32'(bus.core_start), 32'd1);
        chk("add_op", 32'(bus.core_op), 32'd2);
        chk("add_src_b", 32'(bus.core_src_b), 32'd100);
        chk("add_dst", 32'(bus.core_dst), 32'd50);
        @(posedge clk);
        #1;
        chk("start_at_e2", 32'(bus.core_start), 32'd0);
        rd_status("status_wait", 32'h0000_0005);
        pulse_done();
        rd_status("status_after_add", 32'h0001_0001 | IRQB);
        nxt = 1;

        // Spurious done while idle
        pulse_done();
        rd_status("status_spurious", 32'h0001_0011 | IRQB);
        chk("op_held", 32'(bus.core_op), 32'd2);
        wr(OPA, 32'h4000_0000);
        rd_status("status_cleared", 32'h0001_0001);

        // Decode corner cases
        wb_xfer(1'b1, 32'h3000_0004, 32'h8000_0000, rd, ok);
        chk("undecoded_noack", 32'(ok), 32'd0);
        wb_xfer(1'b0, OPA, 32'h0, rd, ok);
        chk("opcode_read_ack", 32'(ok), 32'd1);
        chk("opcode_read_zero", rd, 32'd0);
        wr(STA, 32'h8000_0003);
        rd_status("status_write_ignored", 32'h0001_0001);

        // Held strobe acks every second cycle
        @(negedge clk);
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_adr_i = STA;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.wbs_ack_o) acks++;
        end
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        chk("held_strobe_acks", 32'(acks), 32'd2);

        // Queue fill with the core stalled
        wr(OPA, enc(2'b01, 9'd1, 9'd2, 9'd3));
        wr(OPA, enc(2'b10, 9'd4, 9'd5, 9'd6));
        wr(OPA, enc(2'b11, 9'd7, 9'd8, 9'd9));
        wr(OPA, enc(2'b00, 9'd10, 9'd11, 9'd12));
        wr(OPA, enc(2'b01, 9'd13, 9'd14, 9'd15));
        chk("fill_first_op", 32'(bus.core_op), 32'd1);
        chk("fill_first_src_a", 32'(bus.core_src_a), 32'd1);
        rd_status("status_full", 32'h0001_0406);
        wr(OPA, enc(2'b11, 9'd16, 9'd17, 9'd18));
        rd_status("status_overflow", 32'h0001_040E);
        wr(OPA, 32'h4000_0000);
        rd_status("status_overflow_clr", 32'h0001_0406);
        serve(2'b01, 1'b0);
        serve(2'b10, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rd_status("status_two_queued", 32'h0003_0204);
        chk("third_op", 32'(bus.core_op), 32'd3);

        // Reset mid-operation
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_start", 32'(bus.core_start), 32'd0);
        chk("midrst_fields", {3'b0, bus.core_op, bus.core_src_a, bus.core_src_b, bus.core_dst}, 32'd0);
        chk("midrst_ack_dat", {bus.wbs_ack_o, bus.irq_o, bus.wbs_dat_o[29:0]}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        nxt = start_ops.size();
        rd_status("status_post_reset", 32'h0000_0001);
        pulse_done();
        rd_status("status_late_done", 32'h0000_0011);
        wr(OPA, 32'h4000_0000);

        // In-order drain with one idle cycle between done and next start
        wr(OPA, enc(2'b00, 9'd20, 9'd21, 9'd22));
        wr(OPA, enc(2'b01, 9'd23, 9'd24, 9'd25));
        wr(OPA, enc(2'b10, 9'd26, 9'd27, 9'd28));
        wr(OPA, enc(2'b11, 9'd29, 9'd30, 9'd31));
        serve(2'b00, 1'b0);
        serve(2'b01, 1'b1);
        serve(2'b10, 1'b1);
        serve(2'b11, 1'b1);
        rd_status("status_drained", 32'h0004_0001 | IRQB);

        // Drain interrupt: one pulse, on the edge of the second done only
        wr(OPA, 32'h4000_0000);
        irq_base = irq_cnt;
        wr(OPA, enc(2'b10, 9'd1, 9'd1, 9'd1));
        wr(OPA, enc(2'b11, 9'd2, 9'd2, 9'd2));
        serve(2'b10, 1'b0);
        serve(2'b11, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("irq_pulses", 32'(irq_cnt - irq_base), 32'(IRQN));
`ifdef SCHED_IRQ_EN
        chk("irq_edge", 32'(irq_cyc), 32'(last_done));
`endif
        rd_status("status_irq", 32'h0006_0001 | IRQB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule
